// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address width, register count, zero-register index
// and the write-request types used by the write-side control logic.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;
    localparam int REG_DATA_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t             addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/decoder5_32.sv
// Combinational 5-to-32 one-hot decoder with enable; the write-side mirror of the
// register-file read mux.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regwr_ctrl.sv
// Register-file write controller: small circular write queue that drains one entry per
// unstalled cycle into a registered one-hot write enable. Optional macro REGWR_ZERO_REG_EN
// turns register 31 into a hard-wired zero register.
module regwr_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  stall,
    output logic [NUM_REGS-1:0]   wr_en,
    output logic [DATA_W-1:0]     wr_data,
    output logic [2:0]            count
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    reg_addr_t           addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                accept;
    logic                push;
    logic                pop;
    logic [NUM_REGS-1:0] dec_onehot;
    logic [NUM_REGS-1:0] wr_en_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Ready depends on occupancy alone, so a pop only frees a slot from the next cycle.
    assign in_ready = (count < 3'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign pop      = ~stall & (count != 3'd0);

`ifdef REGWR_ZERO_REG_EN
    assign push       = accept & (in_addr != reg_addr_t'(ZERO_REG));
    assign wr_en_next = dec_onehot & ~(NUM_REGS'(1) << ZERO_REG);
`else
    assign push       = accept;
    assign wr_en_next = dec_onehot;
`endif

    decoder5_32 u_decoder (
        .en     (pop),
        .addr   (addr_mem[rd_ptr]),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_en   <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_en_next;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= next_ptr(rd_ptr);
                wr_data <= data_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_regwr_ctrl.sv
// Testbench for regwr_ctrl: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized stream with resets.
module tb_regwr_ctrl;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_addr;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic [31:0]       wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        count;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic [31:0]       exp_en;
    logic [DATA_W-1:0] exp_data;
    bit                rec_en = 1'b0;
    int                seen[$];

    regwr_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic bit is_zero_reg(input logic [4:0] a);
`ifdef REGWR_ZERO_REG_EN
        return a == 5'd31;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [DATA_W-1:0] d,
                                 input logic s);
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        stall    = s;
        @(posedge clk);
        #2;
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_count", {61'd0, count}, 64'd0);
        checkOutput("rst_wr_en", {32'd0, wr_en}, 64'd0);
        checkOutput("rst_wr_data", wr_data, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #1;
        reset_n = 1'b1;
    endtask

    // Reference model: the queue is the write FIFO; ready and pops are decided from the
    // occupancy seen before the edge, exactly as a handshake would.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_en   = '0;
            exp_data = '0;
        end else begin
            bit   can_acc;
            bit   do_pop;
            ent_t e;
            can_acc = mq.size() < DEPTH;
            do_pop  = !stall && mq.size() > 0;
            exp_en  = '0;
            if (do_pop) begin
                e        = mq.pop_front();
                exp_en   = 32'd1 << e.addr;
                exp_data = e.data;
            end
            if (in_valid && can_acc && !is_zero_reg(in_addr)) begin
                e.addr = in_addr;
                e.data = in_data;
                mq.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n === 1'b1) begin
            checkOutput("wr_en", {32'd0, wr_en}, {32'd0, exp_en});
            checkOutput("wr_data", wr_data, exp_data);
            checkOutput("count", {61'd0, count}, 64'(mq.size()));
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < DEPTH});
            checkOutput("onehot", {63'd0, $onehot0(wr_en)}, 64'd1);
            if (rec_en && wr_en != 32'd0) begin
                seen.push_back($clog2(wr_en));
            end
        end
    end

    initial begin
        int nxt;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        stall    = 1'b0;
        #1;
        checkOutput("init_count", {61'd0, count}, 64'd0);
        checkOutput("init_wr_en", {32'd0, wr_en}, 64'd0);
        checkOutput("init_wr_data", wr_data, 64'd0);
        checkOutput("init_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write
        applyStimulus(1'b1, 5'd5, 64'hA5, 1'b0);
        checkOutput("single_count", {61'd0, count}, 64'd1);
        checkOutput("single_early", {32'd0, wr_en}, 64'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("single_wr_en", {32'd0, wr_en}, 64'h0000_0020);
        checkOutput("single_wr_data", wr_data, 64'hA5);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("single_after", {32'd0, wr_en}, 64'd0);

        // Fill under stall, then drain
        applyStimulus(1'b1, 5'd1, 64'h11, 1'b1);
        applyStimulus(1'b1, 5'd2, 64'h22, 1'b1);
        checkOutput("fill_count", {61'd0, count}, 64'd2);
        checkOutput("fill_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("fill_wr_en", {32'd0, wr_en}, 64'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("drain1", {32'd0, wr_en}, 64'h2);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("drain2", {32'd0, wr_en}, 64'h4);
        checkOutput("drain2_data", wr_data, 64'h22);

        // Full with valid held: no accept, ready returns next cycle, push+pop keeps count
        applyStimulus(1'b1, 5'd3, 64'h33, 1'b1);
        applyStimulus(1'b1, 5'd4, 64'h44, 1'b1);
        applyStimulus(1'b1, 5'd5, 64'h55, 1'b0);
        checkOutput("full_pop", {32'd0, wr_en}, 64'h8);
        checkOutput("full_count", {61'd0, count}, 64'd1);
        checkOutput("full_ready_after", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 5'd5, 64'h55, 1'b0);
        checkOutput("pushpop_count", {61'd0, count}, 64'd1);
        checkOutput("pushpop_wr_en", {32'd0, wr_en}, 64'h10);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("pushpop_last", {32'd0, wr_en}, 64'h20);
        checkOutput("pushpop_data", wr_data, 64'h55);

        // Reset mid-operation discards queued entries
        applyStimulus(1'b1, 5'd7, 64'h77, 1'b1);
        applyStimulus(1'b1, 5'd8, 64'h88, 1'b1);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("pre_reset_wr_en", {32'd0, wr_en}, 64'h80);
        pulseReset();
        rec_en = 1'b1;
        repeat (4) applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        rec_en = 1'b0;
        checkOutput("no_stale_writes", 64'(seen.size()), 64'd0);
        seen.delete();

        // Zero register handling
        applyStimulus(1'b1, 5'd31, 64'h3131, 1'b1);
        applyStimulus(1'b1, 5'd30, 64'h3030, 1'b1);
`ifdef REGWR_ZERO_REG_EN
        checkOutput("zr_count", {61'd0, count}, 64'd1);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("zr_first", {32'd0, wr_en}, 64'h4000_0000);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("zr_second", {32'd0, wr_en}, 64'd0);
`else
        checkOutput("zr_count", {61'd0, count}, 64'd2);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("zr_first", {32'd0, wr_en}, 64'h8000_0000);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("zr_second", {32'd0, wr_en}, 64'h4000_0000);
`endif

        // Ordered stream of ten writes under random stall (exercises pointer wrap)
        nxt    = 0;
        rec_en = 1'b1;
        for (int c = 0; c < 400 && (nxt < 10 || seen.size() < 10); c++) begin
            @(negedge clk);
            stall    = ($urandom_range(0, 2) == 0);
            in_valid = (nxt < 10) && ($urandom_range(0, 3) != 0);
            in_addr  = 5'(nxt);
            in_data  = {$urandom, $urandom};
            if (in_valid && mq.size() < DEPTH) nxt++;
            @(posedge clk);
            #2;
        end
        rec_en = 1'b0;
        checkOutput("stream_len", 64'(seen.size()), 64'd10);
        for (int k = 0; k < seen.size() && k < 10; k++) begin
            checkOutput("stream_order", 64'(seen[k]), 64'(k));
        end

        // Fully random traffic with occasional mid-cycle resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pulseReset();
            in_valid = $urandom_range(0, 1);
            in_addr  = 5'($urandom_range(0, 31));
            in_data  = {$urandom, $urandom};
            stall    = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #2;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regwr_ctrl.md
REGWR_CTRL -- requirements
Module: regwr_ctrl

Interface
REQ-001 Parameter DATA_W, default 64, sets the register data width.
REQ-002 Parameter DEPTH, default 2, sets the write-queue entries; legal values 2 or 4.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  1  indicates that a write request is presented.
REQ-006 in_ready  output  1  indicates that the block can accept a request this cycle.
REQ-007 in_addr  input  5  is the destination register number, 0-31.
REQ-008 in_data  input  DATA_W  is the write data.
REQ-009 stall  input  1  indicates that the register file write port is unavailable this cycle.
REQ-010 wr_en  output  32  is the registered one-hot per-register write enable.
REQ-011 wr_data  output  DATA_W  is the registered write data, aligned with wr_en.
REQ-012 count  output  3  is the current number of queued entries.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL equal (count < DEPTH), combinationally from state only; it SHALL NOT depend on in_valid or stall.
REQ-015 Accepted requests SHALL be stored in a circular FIFO with write/read pointers that wrap from DEPTH-1 to 0.
REQ-016 On each edge with stall=0 and count>0, the head entry SHALL be popped: wr_en <= one-hot of its address, wr_data <= its data.
REQ-017 On any edge without a pop, wr_en SHALL be all-zero; wr_data SHALL hold its last value.
REQ-018 Latency SHALL be: request accepted at edge N into an empty queue with stall=0 at edge N+1 gives wr_en asserted for the cycle after edge N+1. There is no same-cycle bypass from input to output.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, and both operations SHALL complete.
REQ-020 When full, a pop SHALL free a slot; in_ready SHALL rise the cycle after the pop, not the same cycle.
REQ-021 At most one bit of wr_en SHALL be set in any cycle.
REQ-022 Write ordering SHALL be strictly FIFO. Two writes to the same register SHALL reach wr_en in acceptance order.
REQ-023 Stall SHALL freeze the head entry; queue contents SHALL be unaffected apart from pushes.

Reset
REQ-024 Asserting reset_n=0 SHALL immediately clear the count, both pointers, wr_en (all-zero) and wr_data (zero), independent of clk.
REQ-025 Reset mid-operation SHALL discard all queued entries; no wr_en pulse SHALL occur for them.
REQ-026 in_ready SHALL be 1 while in reset and after reset release.

Configuration
REQ-027 Macro REGWR_ZERO_REG_EN, when defined: register 31 is the zero register.
  - A request with in_addr=31 is accepted (handshake completes) but not queued; count does not change.
  - wr_en[31] is constant 0.
REQ-028 Without REGWR_ZERO_REG_EN, register 31 is an ordinary register, handled identically to 0-30.

Structure
REQ-029 Shared package regfile_pkg SHALL hold:
  - REG_ADDR_W=5;
  - NUM_REGS=32;
  - ZERO_REG=31;
  - the typedef reg_addr_t;
  - the typedef wr_req_t, a struct of addr and data.
REQ-030 Sub-module decoder5_32 (combinational 5-to-32 one-hot decoder with enable input) SHALL generate the one-hot vector registered into wr_en. It is the write-side counterpart of the register-file read mux.

Verification
REQ-031 Single write: reset, then in_addr=5, data=0xA5 for one cycle with stall=0 -> one cycle later wr_en=0x0000_0020, wr_data=0xA5; then wr_en=0.
REQ-032 Fill and stall: stall=1, push addr 1, 2 (DEPTH=2) -> count=2, in_ready=0, wr_en=0; release stall -> wr_en=0x2 then 0x4 on consecutive cycles.
REQ-033 Full plus simultaneous events: at count=2, stall=0 and in_valid=1 -> no accept that cycle; next cycle in_ready=1, and push+pop together keeps count=1.
REQ-034 Reset mid-operation: queue 2 entries under stall, pulse reset_n low between edges -> wr_en=0 and count=0 immediately; after release no stale writes appear.
REQ-035 Zero register: with REGWR_ZERO_REG_EN, push addr 31 then addr 30 -> count peaks at 1, only wr_en=0x4000_0000 appears. Without the macro -> wr_en=0x8000_0000 then 0x4000_0000.
REQ-036 Pointer wrap: stream 10 writes to addresses 0-9 under random stall -> outputs in exact order, and the one-hot check holds every cycle.
